// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, default geometry and address checking for sync_data_memory.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 1024;
  // Misaligned, or any bit set above the word index field of the array.
  function automatic logic addr_err(input logic [31:0] a, input int aw);
    return a[1:0] != 2'b0 || (a >> (aw + 2)) != 32'b0;
  endfunction
endpackage

// File: rtl/mem_array_bank.sv
// mem_array_bank: word storage with byte-masked synchronous write and a registered read port.
module mem_array_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NB-1:0]     wmask,
  input  logic              re,
  input  logic              clr,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < NB; i++)
        if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= clr ? '0 : mem[raddr];
endmodule

// File: rtl/sync_data_memory.sv
// sync_data_memory: single-port data memory with IDLE/WAIT/RESP handshake and programmable wait states.
// Define SYNC_MEM_BYTE_LANE_EN to honour byteEn on writes; otherwise full words are always written.
module sync_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req,
  input  logic                writeEnable,
  input  logic [31:0]         Address,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [DATA_W/8-1:0] byteEn,
  output logic                busy,
  output logic                ready,
  output logic [DATA_W-1:0]   MemData,
  output logic                accessErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam logic [3:0] LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [31:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0] be_q;
  logic accept, to_resp, cur_err;
  logic [31:0] cur_addr;
  logic [NB-1:0] wmask;
  // The read is launched on the edge entering RESP; with no wait states that is the accept edge, so use the live address.
  always_comb begin
    accept = state == IDLE && req;
    to_resp = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == LAST);
    cur_addr = state == IDLE ? Address : addr_q;
    cur_err = addr_err(cur_addr, AW);
  end
`ifdef SYNC_MEM_BYTE_LANE_EN
  assign wmask = be_q;
`else
  logic unused_be;
  assign unused_be = ^be_q;
  assign wmask = '1;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      ready <= 1'b0;
      accessErr <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      ready <= to_resp;
      accessErr <= to_resp && cur_err;
      if (accept) begin
        we_q <= writeEnable;
        addr_q <= Address;
        wdata_q <= writeData;
        be_q <= byteEn;
        busy <= 1'b1;
        cnt <= '0;
        state <= (WAIT_STATES == 0) ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
        if (cnt == LAST) state <= RESP;
      end else if (state == RESP) begin
        busy <= 1'b0;
        state <= IDLE;
      end
    end
  mem_array_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
    .clk(Clk),
    .rst(Reset),
    .we(state == RESP && we_q && !accessErr),
    .waddr(addr_q[AW+1:2]),
    .wdata(wdata_q),
    .wmask(wmask),
    .re(to_resp),
    .clr(cur_err),
    .raddr(cur_addr[AW+1:2]),
    .rdata(MemData)
  );
endmodule

// File: doc/sync_data_memory.md
SYNC_DATA_MEMORY -- requirements
Module: sync_data_memory

Interface
REQ-001 SHALL take parameter DATA_W, default 32, meaning the word width in bits; it must be a multiple of 8.
REQ-002 SHALL take parameter DEPTH, default 1024, meaning the number of words; it must be a power of two.
REQ-003 SHALL take parameter WAIT_STATES, default 0, meaning the extra cycles per access, in the range 0..15.
REQ-004 SHALL have port Clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req  in  1  access request, sampled only in IDLE.
REQ-007 SHALL have port writeEnable  in  1  1 selects write, 0 selects read, sampled with req.
REQ-008 SHALL have port Address  in  32  byte address.
REQ-009 SHALL have port writeData  in  DATA_W  write data.
REQ-010 SHALL have port byteEn  in  DATA_W/8  byte-lane write mask.
REQ-011 SHALL have port busy  out  1  high while an access is in flight.
REQ-012 SHALL have port ready  out  1  one-cycle completion pulse.
REQ-013 SHALL have port MemData  out  DATA_W  read data, valid when ready=1 for a read.
REQ-014 SHALL have port accessErr  out  1  error flag, valid with ready.

Function
REQ-015 SHALL decode the word index as Address[log2(DEPTH)+1:2].
REQ-016 SHALL implement the states IDLE, WAIT and RESP.
- IDLE: when req=1, latch writeEnable, Address, writeData and byteEn; go to WAIT if WAIT_STATES>0, else to RESP.
- WAIT: count WAIT_STATES cycles, then go to RESP.
- RESP: ready=1 for exactly one cycle, then go to IDLE.
REQ-017 SHALL raise ready exactly WAIT_STATES+1 cycles after the cycle in which req is accepted.
REQ-018 SHALL hold busy=1 from the cycle after acceptance through the RESP cycle.
REQ-019 SHALL ignore req while not in IDLE; it is never queued.
REQ-020 SHALL accept a new req in the cycle after RESP, giving back-to-back throughput of one access per WAIT_STATES+2 cycles.
REQ-021 SHALL perform the write array update on the RESP edge, so a write is visible to any later read.
REQ-022 SHALL drive MemData from the latched index during RESP, and hold the value until the next RESP.
REQ-023 SHALL drive accessErr=1 in RESP under either condition:
- Address[1:0]!=0 (misaligned);
- any Address bit above log2(DEPTH)+1 is set (out of range).
REQ-024 SHALL, on an errored access, suppress the write and return MemData=0.
REQ-025 SHALL read the newly written value when a read follows a write to the same word (no stale data).

Reset
REQ-026 SHALL, on Reset=1, asynchronously set the state to IDLE and the wait counter to 0.
REQ-027 SHALL hold busy=0, ready=0, accessErr=0 and MemData=0 while in reset.
REQ-028 SHALL drop an access that is in flight when reset asserts; a pending write is not committed.
REQ-029 SHALL leave array contents unchanged by reset.

Configuration
REQ-030 SHALL support the macro SYNC_MEM_BYTE_LANE_EN, which selects how writes use byteEn.
- Defined: each lane i is written only when byteEn[i]=1; an all-zero byteEn gives a completed no-op write.
- Undefined: byteEn is ignored and the full word is always written.

Structure
REQ-031 SHALL place the state enum (IDLE/WAIT/RESP) and the default width and depth constants in the shared package mem_pkg.
REQ-032 SHALL contain a single sub-module, mem_array_bank: the storage array with a synchronous byte-masked write and a registered read port.

Verification
REQ-033 SHALL cover: with WAIT_STATES=0, write 0xDEADBEEF to 0x10, then read 0x10 -> each ready comes 1 cycle after acceptance, and the read returns MemData=0xDEADBEEF.
REQ-034 SHALL cover: with WAIT_STATES=3, read 0x0 -> ready 4 cycles after acceptance; busy high for 4 cycles; a req at cycle 2 is ignored.
REQ-035 SHALL cover: with SYNC_MEM_BYTE_LANE_EN defined, word=0x11223344, then write 0xAABBCCDD with byteEn=4'b0101 -> reads 0x11BB33DD; with the macro undefined -> reads 0xAABBCCDD.
REQ-036 SHALL cover: write to 0x13 (misaligned) and a read of 0x1000 with DEPTH=1024 (out of range) -> accessErr=1, MemData=0, array unchanged.
REQ-037 SHALL cover: assert Reset during WAIT of a write to 0x20 with WAIT_STATES=5 -> outputs 0 immediately; a later read of 0x20 returns the old value.
REQ-038 SHALL cover: write to 0xFFC (last word) and then to 0x0 back-to-back -> both complete, with a cycle spacing of WAIT_STATES+2.
